// File: rtl/limit_pkg.sv
// Shared constants for the N-channel limiter: register map, channel stride and reset limits.
package limit_pkg;

  localparam logic [3:0] OFF_MIN  = 4'h0;
  localparam logic [3:0] OFF_MAX  = 4'h4;
  localparam logic [3:0] OFF_STS  = 4'h8;
  localparam logic [3:0] OFF_STEP = 4'hC;
  localparam int         CH_STRIDE = 16;

  // Most negative dw-bit value, sign-extended to 32 bits.
  function automatic logic [31:0] lim_min_rst(input int dw);
    return 32'hFFFF_FFFF << (dw - 1);
  endfunction

  function automatic logic [31:0] lim_max_rst(input int dw);
    return ~lim_min_rst(dw);
  endfunction

  function automatic logic [19:0] reg_addr(input int ch, input logic [3:0] off);
    return 20'(ch * CH_STRIDE) | {16'd0, off};
  endfunction

endpackage

// File: rtl/red_pitaya_limit_lane.sv
// One limiter channel: clamp with rail flags, range center, and a slew stage when
// CH_SLEW_EN is defined (adds one cycle of latency).
module red_pitaya_limit_lane #(
  parameter int DW = 14
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] x_i,
  input  logic [DW-1:0] min_i,
  input  logic [DW-1:0] max_i,
`ifdef CH_SLEW_EN
  input  logic [DW-1:0] step_i,
`endif
  output logic [DW-1:0] dat_o,
  output logic [1:0]    railed_o,
  output logic [DW-1:0] center_o
);

  logic [DW-1:0] clamp_d, clamp_q;
  logic [1:0]    railed_d, railed_q;
  logic [DW:0]   sum;

  // An inverted range outputs min and flags both rails.
  always_comb begin
    clamp_d  = x_i;
    railed_d = 2'b00;
    if ($signed(min_i) > $signed(max_i)) begin
      clamp_d  = min_i;
      railed_d = 2'b11;
    end else if ($signed(x_i) < $signed(min_i)) begin
      clamp_d  = min_i;
      railed_d = 2'b01;
    end else if ($signed(x_i) > $signed(max_i)) begin
      clamp_d  = max_i;
      railed_d = 2'b10;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clamp_q  <= '0;
      railed_q <= '0;
    end else begin
      clamp_q  <= clamp_d;
      railed_q <= railed_d;
    end
  end

  // Sum in DW+1 bits; dropping the LSB is the arithmetic shift.
  assign sum      = {min_i[DW-1], min_i} + {max_i[DW-1], max_i};
  assign center_o = sum[DW:1];

`ifdef CH_SLEW_EN
  logic [DW-1:0]        slew_d, slew_q;
  logic [1:0]           railed2_d, railed2_q;
  logic signed [DW+1:0] cur, tgt, st, lo, hi, diff, adiff, nxt;
  logic                 st_pos;

  always_comb begin
    cur    = $signed({{2{slew_q[DW-1]}}, slew_q});
    tgt    = $signed({{2{clamp_q[DW-1]}}, clamp_q});
    st     = $signed({{2{step_i[DW-1]}}, step_i});
    lo     = $signed({{2{min_i[DW-1]}}, min_i});
    hi     = $signed({{2{max_i[DW-1]}}, max_i});
    diff   = tgt - cur;
    adiff  = diff[DW+1] ? -diff : diff;
    st_pos = !st[DW+1] && (st != '0);
    nxt    = tgt;
    if (st_pos && (adiff > st))
      nxt = diff[DW+1] ? (cur - st) : (cur + st);
    // A limit change mid-ramp must not leave the output outside the new range.
    if (lo <= hi) begin
      if (nxt < lo)      nxt = lo;
      else if (nxt > hi) nxt = hi;
    end
    slew_d    = nxt[DW-1:0];
    railed2_d = railed_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slew_q    <= '0;
      railed2_q <= '0;
    end else begin
      slew_q    <= slew_d;
      railed2_q <= railed2_d;
    end
  end

  assign dat_o    = slew_q;
  assign railed_o = railed2_q;
`else
  assign dat_o    = clamp_q;
  assign railed_o = railed_q;
`endif

endmodule

// File: rtl/red_pitaya_limit_nch.sv
// N-channel signal limiter with bus-programmable limits and sticky rail status.
// Define CH_SLEW_EN to add a per-channel slew-rate stage and its step register.
module red_pitaya_limit_nch
  import limit_pkg::*;
#(
  parameter int CHN = 2,
  parameter int DW  = 14
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CHN*DW-1:0] dat_i,
  output logic [CHN*DW-1:0] dat_o,
  output logic [2*CHN-1:0]  railed_o,
  output logic [CHN*DW-1:0] center_o,
  input  logic [31:0]       sys_addr,
  input  logic [31:0]       sys_wdata,
  input  logic              sys_wen,
  input  logic              sys_ren,
  output logic [31:0]       sys_rdata,
  output logic              sys_err,
  output logic              sys_ack
);

  localparam logic [31:0]   MIN_RST32 = lim_min_rst(DW);
  localparam logic [31:0]   MAX_RST32 = lim_max_rst(DW);
  localparam logic [DW-1:0] MIN_RST   = MIN_RST32[DW-1:0];
  localparam logic [DW-1:0] MAX_RST   = MAX_RST32[DW-1:0];

  logic [CHN-1:0][DW-1:0] min_d, min_q, max_d, max_q;
  logic [CHN-1:0][1:0]    sticky_d, sticky_q, clr;
  logic [31:0]            rdata_d, rdata_q;
  logic                   ack_d, ack_q, err_d, err_q;
`ifdef CH_SLEW_EN
  logic [CHN-1:0][DW-1:0] step_d, step_q;
`endif

  logic unused_bits;
  assign unused_bits = ^{sys_addr[31:20], sys_wdata[31:DW]};

  function automatic logic [31:0] sext(input logic [DW-1:0] v);
    return {{(32-DW){v[DW-1]}}, v};
  endfunction

  always_comb begin
    min_d   = min_q;
    max_d   = max_q;
    clr     = '0;
    rdata_d = '0;
    ack_d   = sys_wen | sys_ren;
    err_d   = 1'b0;
`ifdef CH_SLEW_EN
    step_d  = step_q;
`endif
    for (int n = 0; n < CHN; n++) begin
      if (sys_wen) begin
        if (sys_addr[19:0] == reg_addr(n, OFF_MIN)) min_d[n] = sys_wdata[DW-1:0];
        if (sys_addr[19:0] == reg_addr(n, OFF_MAX)) max_d[n] = sys_wdata[DW-1:0];
        if (sys_addr[19:0] == reg_addr(n, OFF_STS)) clr[n]   = sys_wdata[1:0];
`ifdef CH_SLEW_EN
        if (sys_addr[19:0] == reg_addr(n, OFF_STEP)) step_d[n] = sys_wdata[DW-1:0];
`endif
      end
      // Set is ORed in after the clear so a same-cycle rail event survives.
      sticky_d[n] = (sticky_q[n] & ~clr[n]) | railed_o[2*n +: 2];
      if (sys_ren) begin
        if (sys_addr[19:0] == reg_addr(n, OFF_MIN)) rdata_d = sext(min_q[n]);
        if (sys_addr[19:0] == reg_addr(n, OFF_MAX)) rdata_d = sext(max_q[n]);
        if (sys_addr[19:0] == reg_addr(n, OFF_STS)) rdata_d = {30'd0, sticky_q[n]};
`ifdef CH_SLEW_EN
        if (sys_addr[19:0] == reg_addr(n, OFF_STEP)) rdata_d = sext(step_q[n]);
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < CHN; n++) begin
        min_q[n] <= MIN_RST;
        max_q[n] <= MAX_RST;
      end
      sticky_q <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef CH_SLEW_EN
      step_q   <= '0;
`endif
    end else begin
      min_q    <= min_d;
      max_q    <= max_d;
      sticky_q <= sticky_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
`ifdef CH_SLEW_EN
      step_q   <= step_d;
`endif
    end
  end

  assign sys_rdata = rdata_q;
  assign sys_ack   = ack_q;
  assign sys_err   = err_q;

  for (genvar n = 0; n < CHN; n++) begin : g_lane
    red_pitaya_limit_lane #(.DW(DW)) u_lane (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .x_i      (dat_i[n*DW +: DW]),
      .min_i    (min_q[n]),
      .max_i    (max_q[n]),
`ifdef CH_SLEW_EN
      .step_i   (step_q[n]),
`endif
      .dat_o    (dat_o[n*DW +: DW]),
      .railed_o (railed_o[2*n +: 2]),
      .center_o (center_o[n*DW +: DW])
    );
  end

endmodule

// File: doc/red_pitaya_limit_nch.md
RED_PITAYA_LIMIT_NCH -- requirements
Module: red_pitaya_limit_nch

Interface
REQ-001 SHALL have parameter CHN, default 2: number of limiter channels, 1..8.
REQ-002 SHALL have parameter DW, default 14: signed sample width, 8..16.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port dat_i, input, CHN*DW: signed samples, channel n at bits [n*DW +: DW].
REQ-006 SHALL have port dat_o, output, CHN*DW: limited samples, same packing as dat_i.
REQ-007 SHALL have port railed_o, output, 2*CHN: live rail flags; bit 2n = channel n lower rail, bit 2n+1 = upper rail.
REQ-008 SHALL have port center_o, output, CHN*DW: per-channel (min+max)>>>1.
REQ-009 SHALL have ports sys_addr (input, 32), sys_wdata (input, 32), sys_wen (input, 1), sys_ren (input, 1), sys_rdata (output reg, 32), sys_err (output reg, 1) and sys_ack (output reg, 1): the system bus.

Function
REQ-010 SHALL decode sys_addr[19:0] per channel n at base n*0x10 as: +0x0 min (RW), +0x4 max (RW), +0x8 sticky status (read; write-1-to-clear), +0xC slew step (RW, macro only).
REQ-011 SHALL assert sys_ack one cycle after any cycle with sys_wen|sys_ren, keep sys_err at 0, and read unmapped addresses as 0.
REQ-012 SHALL sign-extend register readback of min, max and step to 32 bits.
REQ-013 SHALL register dat_o: a sample on dat_i appears on dat_o exactly 1 cycle later (2 cycles with CH_SLEW_EN).
REQ-014 SHALL drive dat_o = min and set the lower flag when x < min, drive dat_o = max and set the upper flag when x > max, and otherwise pass x with both flags 0; x == min or x == max is not railed.
REQ-015 SHALL treat min > max as an invalid range: output min and set both flags.
REQ-016 SHALL register railed_o so that it is aligned with dat_o.
REQ-017 SHALL set sticky status bits [1:0] whenever the corresponding railed_o bit is 1; bits hold until cleared by writing 1 to them.
REQ-018 SHALL let a set win over a clear when both occur in the same cycle.
REQ-019 SHALL compute center in DW+1 bits without overflow before the arithmetic shift.
REQ-020 SHALL take effect on the next sample after a min/max write; no output glitch beyond that cycle.

Reset
REQ-021 SHALL on rst_i set min = -2^(DW-1) and max = 2^(DW-1)-1 for all channels, step to 0, and dat_o, railed_o, sticky status, sys_ack and sys_err to 0.
REQ-022 SHALL, when rst_i is asserted mid-operation, return to the REQ-021 state on the next edge and discard any pending bus ack.

Configuration
REQ-023 SHALL compile a per-channel slew-rate limiter when CH_SLEW_EN is defined: a stage after the clamp steps the output toward the clamped value by at most step per cycle; step = 0 disables slewing; the result stays within [min, max].
REQ-024 SHALL, when CH_SLEW_EN is undefined, omit the slew stage, read +0xC as 0, ignore writes to +0xC, and use 1-cycle latency.

Structure
REQ-025 SHALL keep the register offsets (0x0/0x4/0x8/0xC), the channel stride 0x10 and the reset-limit functions in the shared package limit_pkg.
REQ-026 SHALL instantiate sub-module red_pitaya_limit_lane once per channel; the lane contains clamp, flags, center and optional slew, and the top contains the bus decode and sticky registers.

Verification
REQ-027 SHALL cover: after reset, DW=14, dat_i ch0 = -8192 -> dat_o = -8192, railed_o = 0, read +0x0 = 0xFFFFE000.
REQ-028 SHALL cover: write min = -100, max = 200 on ch1; input 500 -> dat_o = 200, railed bit 3 = 1; input -300 -> -100, bit 2 = 1; input 200 -> 200, flags 0.
REQ-029 SHALL cover: after an upper-rail event, read 0x18 = 2; write 0x18 = 2 in the same cycle the rail recurs -> still reads 2; a later clear with no rail event -> reads 0.
REQ-030 SHALL cover: min = 50, max = 10 -> dat_o = 50, both flags = 1, center = 30.
REQ-031 SHALL cover, with CH_SLEW_EN and step = 10: input step from 0 to 100 -> dat_o ramps 10, 20, ..., 100 over 10 cycles.
REQ-032 SHALL cover: assert rst_i during a read -> no sys_ack, and limits read back at their reset values.
